// File: rtl/lcd_bus_pkg.sv
// rtl/lcd_bus_pkg.sv - shared constants, status layout and read FSM states for lcd_bus_slave
package lcd_bus_pkg;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  // Status word returned on rs=0 reads
  localparam int STAT_OVF       = 15;
  localparam int STAT_FULL      = 14;
  localparam int STAT_EMPTY     = 13;
  localparam int STAT_COUNT_MSB = 7;
  localparam int STAT_COUNT_LSB = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } rd_state_e;

  function automatic logic [15:0] make_status(input logic       ovf,
                                              input logic       full,
                                              input logic       empty,
                                              input logic [7:0] count);
    logic [15:0] s;
    s = '0;
    s[STAT_OVF]                      = ovf;
    s[STAT_FULL]                     = full;
    s[STAT_EMPTY]                    = empty;
    s[STAT_COUNT_MSB:STAT_COUNT_LSB] = count;
    return s;
  endfunction

endpackage

// File: rtl/lcd_bus_slave_if.sv
// rtl/lcd_bus_slave_if.sv - 16-bit 8080-style LCD bus pins (cs/rs/wr/rd/data)
// master: MCU side, drives strobes and data_i, observes data_o/data_oe
// slave : panel-emulating side, samples strobes, drives data_o/data_oe
interface lcd_bus_slave_if;
  logic        cs;
  logic        rs;
  logic        wr;
  logic        rd;
  logic [15:0] data_i;
  logic [15:0] data_o;
  logic        data_oe;

  modport master (output cs, output rs, output wr, output rd, output data_i,
                  input data_o, input data_oe);
  modport slave  (input cs, input rs, input wr, input rd, input data_i,
                  output data_o, output data_oe);
endinterface

// File: rtl/lcd_bus_fifo.sv
// rtl/lcd_bus_fifo.sv - synchronous write-word queue with head-hold when empty
// pclk/prst : clock, async active-low reset
// push/push_word : enqueue request (accepted when not full or popping)
// pop : dequeue head (ignored when empty)
// full/empty/count/head : occupancy and head word
module lcd_bus_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 17
) (
  input  logic                       pclk,
  input  logic                       prst,
  input  logic                       push,
  input  logic [W-1:0]               push_word,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [W-1:0]               head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  last_q, last_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A full queue still takes a push when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // When drained, keep presenting the most recently popped word
  assign head = empty ? last_q : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      last_d   = mem[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: it is only observed through valid entries
  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr_q] <= push_word;
  end

endmodule

// File: rtl/lcd_bus_slave.sv
// rtl/lcd_bus_slave.sv - responder end of the 8080 LCD bus: queues MCU writes, answers MCU reads
// pclk/prst : clock, async active-low reset
// bus : LCD pins (slave modport)
// out_valid/out_ready/out_is_data/out_word : queued write words to internal logic
// rd_word/rd_req : word returned on rs=1 reads, pulse when it is latched
// ovf/ovf_clr : sticky overflow flag and its clear
module lcd_bus_slave
  import lcd_bus_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            pclk,
  input  logic            prst,
  lcd_bus_slave_if.slave  bus,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_is_data,
  output logic [15:0]     out_word,
  input  logic [15:0]     rd_word,
  output logic            rd_req,
  output logic            ovf,
  input  logic            ovf_clr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Strobe synchronizers idle high; rs/data ride a plain pipe of equal length
  logic [SYNC_STAGES-1:0] cs_sync_q, wr_sync_q, rd_sync_q;
  logic [16:0]            dpipe_q [SYNC_STAGES];
  logic                   wr_prev_q, rd_prev_q;

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      cs_sync_q <= '1;
      wr_sync_q <= '1;
      rd_sync_q <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) dpipe_q[i] <= '0;
      wr_prev_q <= 1'b1;
      rd_prev_q <= 1'b1;
    end else begin
      cs_sync_q[0] <= bus.cs;
      wr_sync_q[0] <= bus.wr;
      rd_sync_q[0] <= bus.rd;
      dpipe_q[0]   <= {bus.rs, bus.data_i};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync_q[i] <= cs_sync_q[i-1];
        wr_sync_q[i] <= wr_sync_q[i-1];
        rd_sync_q[i] <= rd_sync_q[i-1];
        dpipe_q[i]   <= dpipe_q[i-1];
      end
      wr_prev_q <= wr_sync_q[SYNC_STAGES-1];
      rd_prev_q <= rd_sync_q[SYNC_STAGES-1];
    end
  end

  logic        cs_s, wr_s, rd_s, rs_d;
  logic [15:0] data_d;
  logic        wr_rise, rd_fall;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign wr_s   = wr_sync_q[SYNC_STAGES-1];
  assign rd_s   = rd_sync_q[SYNC_STAGES-1];
  assign rs_d   = dpipe_q[SYNC_STAGES-1][16];
  assign data_d = dpipe_q[SYNC_STAGES-1][15:0];

  assign wr_rise = wr_s && !wr_prev_q && !cs_s;
  // A read only starts while no write strobe is active
  assign rd_fall = !rd_s && rd_prev_q && !cs_s && wr_s;

  // Write requests are registered once before entering the queue
  logic        push_q, push_d;
  logic [16:0] push_word_q, push_word_d;

  assign push_d      = wr_rise;
  assign push_word_d = wr_rise ? {rs_d, data_d} : push_word_q;

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      push_q      <= 1'b0;
      push_word_q <= '0;
    end else begin
      push_q      <= push_d;
      push_word_q <= push_word_d;
    end
  end

  logic          fifo_full, fifo_empty, pop;
  logic [CW-1:0] fifo_count;
  logic [16:0]   fifo_head;

  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign out_is_data = fifo_head[16];
  assign out_word    = fifo_head[15:0];

  lcd_bus_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (17)
  ) u_fifo (
    .pclk      (pclk),
    .prst      (prst),
    .push      (push_q),
    .push_word (push_word_q),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Overflow: a set in the same cycle as a clear wins
  logic ovf_q, ovf_d, drop;

  assign drop = push_q && fifo_full && !pop;

  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

  logic [15:0] status;
  assign status = make_status(ovf_q, fifo_full, fifo_empty, 8'(fifo_count));

  // Read FSM: the response is frozen at read start and held while driving
  rd_state_e   state_q;
  logic [15:0] data_o_q;
  logic        data_oe_q;
  logic        rd_req_q;

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q   <= IDLE;
      data_o_q  <= '0;
      data_oe_q <= 1'b0;
      rd_req_q  <= 1'b0;
    end else begin
      rd_req_q <= 1'b0;
      case (state_q)
        IDLE: begin
          data_oe_q <= 1'b0;
          if (rd_fall) begin
            state_q   <= DRIVE;
            data_oe_q <= 1'b1;
            data_o_q  <= (rs_d == RS_DATA) ? rd_word : status;
            rd_req_q  <= (rs_d == RS_DATA);
          end
        end
        DRIVE: begin
          if (rd_s || cs_s) begin
            state_q   <= IDLE;
            data_oe_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          data_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_o  = data_o_q;
  assign bus.data_oe = data_oe_q;
  assign rd_req      = rd_req_q;

endmodule
